// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N_CH valid/ready stream demultiplexer.
// The destination channel is taken from in_sel on the first beat of a
// packet and locked until the beat carrying in_last. A single output
// register (hold_*) gives one cycle of latency at full throughput.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready is combinational from out_ready)
//   in_data, in_sel,      input beat payload, destination and end-of-packet flag
//   in_last
//   out_valid[N_CH]       one-hot channel valid (or all zero)
//   out_ready[N_CH]       per-channel ready
//   out_data, out_last    shared payload of the held beat
//   busy                  a multi-beat packet is open
//   drop_cnt (optional)   saturating count of packets dropped for an
//                         out-of-range select; present only when the macro
//                         STREAM_DEMUX_DROP_CNT_EN is defined
module stream_demux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_CH  = 8,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_last,
    output logic [N_CH-1:0]  out_valid,
    input  logic [N_CH-1:0]  out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    localparam int unsigned CNT_W = 16;
    localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   chan_q, chan_d;
    logic               drop_q, drop_d;

    logic               hold_vld_q, hold_vld_d;
    logic [SEL_W-1:0]   hold_ch_q, hold_ch_d;
    logic [WIDTH-1:0]   hold_data_q, hold_data_d;
    logic               hold_last_q, hold_last_d;

    logic               drain_c;
    logic               accept_c;
    logic               sel_oor_c;
    logic [SEL_W-1:0]   route_ch_c;
    logic               route_drop_c;

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
`endif

    // Decode the held beat onto its one-hot channel valid.
    always_comb begin
        out_valid = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            out_valid[k] = hold_vld_q && (hold_ch_q == SEL_W'(k));
        end
    end

    // Only the selected channel's ready matters; others are masked by out_valid.
    assign drain_c   = |(out_valid & out_ready);
    assign in_ready  = !hold_vld_q || drain_c;
    assign accept_c  = in_valid && in_ready;
    // Can only be true when N_CH is not a power of two.
    assign sel_oor_c = ({1'b0, in_sel} >= N_CH_L);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic: lock channel and drop flag on the first beat.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        drop_d  = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    chan_d = in_sel;
                    drop_d = sel_oor_c && !in_last;
                    if (!in_last) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (accept_c && in_last) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: route the beat and update the hold register.
    always_comb begin
        route_ch_c   = (state_q == ST_LOCKED) ? chan_q : in_sel;
        route_drop_c = (state_q == ST_LOCKED) ? drop_q : sel_oor_c;

        hold_vld_d  = hold_vld_q;
        hold_ch_d   = hold_ch_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;

        if (drain_c) begin
            hold_vld_d = 1'b0;
        end
        // A load in the same cycle as a drain overrides the clear.
        if (accept_c && !route_drop_c) begin
            hold_vld_d  = 1'b1;
            hold_ch_d   = route_ch_c;
            hold_data_d = in_data;
            hold_last_d = in_last;
        end

        busy     = (state_q == ST_LOCKED);
        out_data = hold_data_q;
        out_last = hold_last_q;
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    // Count dropped packets on their first beat, saturating.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept_c && (state_q == ST_IDLE) && sel_oor_c && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // Output hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld_q  <= 1'b0;
            hold_ch_q   <= '0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_ch_q   <= hold_ch_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: two instances (N_CH=8 and N_CH=6) share one input
// stream. A queue-based reference model predicts the held beat per instance;
// a negedge monitor compares every visible output against the model.
module tb_stream_demux;

    localparam int unsigned W     = 8;
    localparam int unsigned SEL_W = 3;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_last;
    logic [7:0]       ordy [2];

    logic             rdy8, rdy6, ol8, ol6, bz8, bz6;
    logic [7:0]       ov8;
    logic [5:0]       ov6;
    logic [W-1:0]     od8, od6;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0]      dc8, dc6;
`endif

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(W), .N_CH(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (rdy8),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_last  (in_last),
        .out_valid(ov8),
        .out_ready(ordy[0]),
        .out_data (od8),
        .out_last (ol8),
        .busy     (bz8)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt (dc8)
`endif
    );

    stream_demux #(.WIDTH(W), .N_CH(6)) u_dut6 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (rdy6),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_last  (in_last),
        .out_valid(ov6),
        .out_ready(ordy[1][5:0]),
        .out_data (od6),
        .out_last (ol6),
        .busy     (bz6)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt (dc6)
`endif
    );

    // Reference model state: at most one beat can be waiting per instance.
    beat_t sb [2][$];
    bit    open_m [2];
    bit    drop_m [2];
    int    chan_m [2];
    int    dcnt_m [2];

    int    n_chk  = 0;
    int    n_fail = 0;

    function automatic int nch(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic bit exp_ready(input int d);
        if (sb[d].size() == 0) return 1'b1;
        return ordy[d][sb[d][0].ch];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using pre-edge input values.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit    rdy;
            bit    dropped;
            int    ch;
            beat_t b;
            if (rst) begin
                sb[d].delete();
                open_m[d] = 1'b0;
                drop_m[d] = 1'b0;
                chan_m[d] = 0;
                dcnt_m[d] = 0;
            end else begin
                rdy = exp_ready(d);
                if (sb[d].size() > 0 && ordy[d][sb[d][0].ch]) begin
                    void'(sb[d].pop_front());
                end
                if (in_valid && rdy) begin
                    if (open_m[d]) begin
                        ch      = chan_m[d];
                        dropped = drop_m[d];
                    end else begin
                        ch        = int'(in_sel);
                        dropped   = (ch >= nch(d));
                        chan_m[d] = ch;
                        drop_m[d] = dropped;
                        if (dropped && dcnt_m[d] < 65535) dcnt_m[d]++;
                    end
                    if (!dropped) begin
                        b.ch   = ch;
                        b.data = in_data;
                        b.last = in_last;
                        sb[d].push_back(b);
                    end
                    open_m[d] = !in_last;
                end
            end
        end
    endtask

    // Compare everything the DUTs present against the model.
    task automatic monitor_step();
        for (int d = 0; d < 2; d++) begin
            logic [63:0] exp_ov;
            logic        a_rdy, a_last, a_bz;
            logic [63:0] a_ov;
            logic [7:0]  a_dat;
            a_rdy  = (d == 0) ? rdy8 : rdy6;
            a_ov   = (d == 0) ? 64'(ov8) : 64'(ov6);
            a_dat  = (d == 0) ? od8 : od6;
            a_last = (d == 0) ? ol8 : ol6;
            a_bz   = (d == 0) ? bz8 : bz6;
            exp_ov = (sb[d].size() > 0) ? (64'd1 << sb[d][0].ch) : 64'd0;
            check($sformatf("dut%0d in_ready", nch(d)), 64'(a_rdy), 64'(exp_ready(d)));
            check($sformatf("dut%0d out_valid", nch(d)), a_ov, exp_ov);
            check($sformatf("dut%0d busy", nch(d)), 64'(a_bz), 64'(open_m[d]));
            if (sb[d].size() > 0) begin
                check($sformatf("dut%0d out_data", nch(d)), 64'(a_dat), 64'(sb[d][0].data));
                check($sformatf("dut%0d out_last", nch(d)), 64'(a_last), 64'(sb[d][0].last));
            end
`ifdef STREAM_DEMUX_DROP_CNT_EN
            check($sformatf("dut%0d drop_cnt", nch(d)), 64'((d == 0) ? dc8 : dc6), 64'(dcnt_m[d]));
`endif
        end
    endtask

    task automatic beat(input bit v, input logic [7:0] dat, input logic [2:0] sel, input bit last);
        in_valid = v;
        in_data  = dat;
        in_sel   = sel;
        in_last  = last;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sel   = '0;
        in_last  = 1'b0;
        ordy[0]  = 8'hFF;
        ordy[1]  = 8'hFF;

        fork
            forever begin
                @(posedge clk);
                model_step();
            end
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset and idle.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset out_data dut8", 64'(od8), 64'd0);
        check("reset out_data dut6", 64'(od6), 64'd0);
        check("reset out_valid dut8", 64'(ov8), 64'd0);
        check("reset in_ready dut8", 64'(rdy8), 64'd1);

        // One single-beat packet per channel, back to back.
        for (int s = 0; s < 8; s++) begin
            beat(1'b1, 8'(8'hA0 + s), 3'(s), 1'b1);
        end
        beat(1'b0, 8'h00, 3'd0, 1'b0);

        // Packet lock: later in_sel values are ignored.
        beat(1'b1, 8'h11, 3'd3, 1'b0);
        beat(1'b1, 8'h22, 3'd5, 1'b0);
        beat(1'b1, 8'h33, 3'd5, 1'b1);
        beat(1'b0, 8'h00, 3'd0, 1'b0);

        // Backpressure on channel 2, then drain with simultaneous accept.
        beat(1'b1, 8'h55, 3'd2, 1'b1);
        ordy[0][2] = 1'b0;
        ordy[1][2] = 1'b0;
        repeat (4) beat(1'b1, 8'h66, 3'd1, 1'b1);
        ordy[0][2] = 1'b1;
        ordy[1][2] = 1'b1;
        beat(1'b1, 8'h66, 3'd1, 1'b1);
        beat(1'b0, 8'h00, 3'd0, 1'b0);

        // Out-of-range select on the 6-channel instance.
        beat(1'b1, 8'h77, 3'd7, 1'b0);
        beat(1'b1, 8'h88, 3'd0, 1'b1);
        beat(1'b0, 8'h00, 3'd0, 1'b0);

        // Reset in the middle of a packet, then a fresh packet.
        beat(1'b1, 8'h44, 3'd4, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post-reset busy dut8", 64'(bz8), 64'd0);
        check("post-reset out_valid dut8", 64'(ov8), 64'd0);
        beat(1'b1, 8'h99, 3'd1, 1'b1);
        beat(1'b0, 8'h00, 3'd0, 1'b0);

        // Randomised traffic with random backpressure.
        repeat (1500) begin
            ordy[0] = 8'($urandom) | 8'($urandom);
            ordy[1] = 8'($urandom) | 8'($urandom);
            beat(($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0));
        end

        ordy[0] = 8'hFF;
        ordy[1] = 8'hFF;
        repeat (4) beat(1'b0, 8'h00, 3'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered 1-to-N stream demultiplexer. Successor to the combinational 1-to-8 DMUX.
- Routes a valid/ready input stream to one of N_CH output channels, which are selected per packet.
- The select is locked for the whole packet, from the first beat up to and including the beat with in_last.
- One output register stage gives full throughput and one cycle of latency. The block sits between a single producer and N consumer blocks.

Parameters:
- WIDTH, 8, data bits per beat.
- N_CH, 8, number of output channels, 2..64.
- SEL_W, $clog2(N_CH), select width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_data  input  WIDTH  input beat data.
- in_sel  input  SEL_W  destination channel. Sampled only on the first beat of a packet.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  N_CH  one-hot channel valid, or all zero.
- out_ready  input  N_CH  per-channel ready.
- out_data  output  WIDTH  shared output data bus. Meaningful only where out_valid is set.
- out_last  output  1  last flag of the held beat.
- busy  output  1  a packet is open (state LOCKED).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE; the output register is empty.
  - out_valid = 0, out_data = 0, out_last = 0, busy = 0, in_ready = 1 after reset.
  - A packet in flight is abandoned. No partial beat is emitted after reset.
- Handshakes:
  - Input transfer: in_valid && in_ready at a clk edge.
  - Output transfer on channel k: out_valid[k] && out_ready[k].
- Output register: hold_vld, hold_ch, hold_data, hold_last.
- in_ready = !hold_vld || out_ready[hold_ch]. This is combinational from out_ready, and gives back-to-back transfers with no bubble.
- Latency: a beat accepted at edge t appears on out_valid/out_data after edge t. The one-hot bit is hold_ch.
- out_valid[k] = hold_vld && (hold_ch == k).
- Data must stay stable while out_valid[k]=1 and out_ready[k]=0.
- State machine:
  - IDLE: on an input transfer, chan_q <= in_sel.
    - in_last=0 -> LOCKED.
    - in_last=1 -> stay IDLE (single-beat packet).
  - LOCKED: every input transfer uses chan_q, and in_sel is ignored.
    - A transfer with in_last=1 -> IDLE.
  - busy = (state == LOCKED).
- The routed channel for a beat is in_sel in IDLE and chan_q in LOCKED.
- Out-of-range select:
  - Applies when in_sel >= N_CH in IDLE. This is only possible when N_CH is not a power of two.
  - The whole packet is accepted and discarded: in_ready follows the rule above, and the output register is not loaded.
  - A drop flag is held in LOCKED until the last beat.
- Simultaneous accept and drain:
  - When the held beat drains and a new beat is accepted at the same edge, the register is reloaded.
  - hold_vld stays 1, and hold_ch may change channel in that cycle.
- out_ready bits of non-selected channels are ignored.
- in_sel/in_data/in_last are don't-care while in_valid=0.
- No combinational path from in_valid to out_valid.

Optional Feature:
- Macro: STREAM_DEMUX_DROP_CNT_EN.
- Defined:
  - Adds port drop_cnt, output, 16 bits.
  - It counts packets discarded due to an out-of-range select, incrementing on the first beat of each such packet.
  - Saturates at 16'hFFFF and resets to 0.
- Undefined:
  - Port absent; drops are silent.
  - Routing behaviour is identical in both cases.

Test Plan:
- Reset and idle:
  - Stimulus: rst=1 for 2 cycles, in_valid=0.
  - Required: out_valid=8'h00, out_data=0, in_ready=1, busy=0.
- Single-beat per channel:
  - Stimulus: N_CH=8, all out_ready=1. For s=0..7, send in_data=8'hA0+s, in_sel=s, in_last=1.
  - Required: the next cycle out_valid=8'b1<<s and out_data=8'hA0+s. Throughput is 1 beat per cycle and busy stays 0.
- Packet lock:
  - Stimulus: 3-beat packet (11,22,33). in_sel=3 on beat 1, in_sel=5 on beats 2-3, last on beat 3.
  - Required: all three beats appear on channel 3 (out_valid=8'h08). busy=1 from after beat 1 until after beat 3.
- Backpressure:
  - Stimulus: out_ready[2]=0 for 4 cycles while a beat is held on channel 2.
  - Required: in_ready=0, and out_data/out_valid stay stable. out_ready[2]=1 -> beat drains, with a simultaneous accept of the next beat.
- Out-of-range:
  - Stimulus: N_CH=6, send a 2-beat packet with in_sel=7.
  - Required: both beats are accepted, out_valid stays 0, and drop_cnt goes 0 -> 1 when STREAM_DEMUX_DROP_CNT_EN is defined.
- Reset mid-packet:
  - Stimulus: assert rst after beat 1 of a 3-beat packet to channel 4.
  - Required: out_valid=0 and busy=0. Then send a new packet with in_sel=1; it routes to channel 1.
